// File: rtl/melbank_rom_arbiter_if.sv
// melbank_rom_arbiter_if: request, return and ROM buses of the mel-filterbank ROM arbiter.
// master drives requests and ROM data; slave is the arbiter.
interface melbank_rom_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
);
  logic                  req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr, rom_addr;
  logic [LEN_WIDTH-1:0]  req0_len, req1_len;
  logic                  rd0_valid, rd1_valid, rd0_last, rd1_last, busy;
  logic [DATA_WIDTH-1:0] rd0_data, rd1_data, rom_rddata;
  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len, rom_rddata,
    input  req0_ready, req1_ready, rd0_valid, rd1_valid, rd0_data, rd1_data,
           rd0_last, rd1_last, rom_addr, busy
  );
  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len, rom_rddata,
    output req0_ready, req1_ready, rd0_valid, rd1_valid, rd0_data, rd1_data,
           rd0_last, rd1_last, rom_addr, busy
  );
endinterface

// File: rtl/melbank_rom_arbiter.sv
// melbank_rom_arbiter: two-requester burst arbiter/sequencer for the mel-filterbank coefficient ROM.
// Define MELBANK_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module melbank_rom_arbiter #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 10,
  parameter int ROM_LATENCY = 1
) (
  input logic                 clk_tb,
  input logic                 tb_rst,
  melbank_rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic issued;
    logic owner;
    logic last;
  } meta_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, acc_addr;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, acc_len;
  meta_t                 meta_q, meta_d, exit_m;
  meta_t                 sr_q [ROM_LATENCY];
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic                  v0_q, v0_d, v1_q, v1_d, l0_q, l0_d, l1_q, l1_d;
  logic                  gnt1, accept;
`ifdef MELBANK_ARB_FIXED_PRIO_EN
  assign gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
  logic last_q;
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  always_ff @(posedge clk_tb or posedge tb_rst)
    if (tb_rst) last_q <= 1'b1;
    else if (accept) last_q <= gnt1;
`endif
  assign accept     = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid) & ~tb_rst;
  assign acc_addr   = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign acc_len    = gnt1 ? bus.req1_len : bus.req0_len;
  assign exit_m     = sr_q[ROM_LATENCY-1];
  assign bus.req0_ready = accept & ~gnt1;
  assign bus.req1_ready = accept & gnt1;
  assign bus.rom_addr   = addr_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.rd0_valid  = v0_q;
  assign bus.rd1_valid  = v1_q;
  assign bus.rd0_last   = l0_q;
  assign bus.rd1_last   = l1_q;
  assign bus.rd0_data   = d0_q;
  assign bus.rd1_data   = d1_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    meta_d  = meta_q;
    if (accept) begin
      addr_d  = acc_addr;
      cnt_d   = acc_len;
      meta_d  = '{issued: acc_len != '0, owner: gnt1, last: acc_len == LEN_WIDTH'(1)};
      state_d = acc_len != '0 ? ISSUE : IDLE;
    end else if (state_q == ISSUE) begin
      if (cnt_q == LEN_WIDTH'(1)) begin
        state_d = DRAIN;
        cnt_d   = LEN_WIDTH'(ROM_LATENCY - 1);
        meta_d  = '0;
      end else begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        cnt_d       = cnt_q - LEN_WIDTH'(1);
        meta_d.last = cnt_q == LEN_WIDTH'(2);
      end
    end else if (state_q == DRAIN) begin
      state_d = cnt_q == '0 ? IDLE : DRAIN;
      cnt_d   = cnt_q - LEN_WIDTH'(1);
    end
  end
  // Return words are routed by the owner tag that travelled with the address.
  always_comb begin
    v0_d = exit_m.issued & ~exit_m.owner;
    v1_d = exit_m.issued & exit_m.owner;
    l0_d = v0_d & exit_m.last;
    l1_d = v1_d & exit_m.last;
    d0_d = v0_d ? bus.rom_rddata : d0_q;
    d1_d = v1_d ? bus.rom_rddata : d1_q;
  end
  always_ff @(posedge clk_tb or posedge tb_rst)
    if (tb_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      meta_q  <= '0;
      sr_q    <= '{default: '0};
      {v0_q, v1_q, l0_q, l1_q} <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      meta_q  <= meta_d;
      sr_q[0] <= meta_q;
      for (int k = 1; k < ROM_LATENCY; k++) sr_q[k] <= sr_q[k-1];
      {v0_q, v1_q, l0_q, l1_q} <= {v0_d, v1_d, l0_d, l1_d};
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
endmodule

// File: tb/tb_melbank_rom_arbiter.sv
// tb_melbank_rom_arbiter: directed checks of the ROM arbiter with a latency-1 ROM holding data = addr[7:0].
module tb_melbank_rom_arbiter;
  logic clk_tb, tb_rst;
  int   tests, fails;
  int   n_gr;
  logic gr [16];
  int   tg [16];
  logic bz [16];
  melbank_rom_arbiter_if bus ();
  melbank_rom_arbiter dut (.clk_tb(clk_tb), .tb_rst(tb_rst), .bus(bus));
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;
  always @(posedge clk_tb) bus.rom_rddata <= bus.rom_addr[7:0];
  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Called at the point just after the acceptance edge; checks len+2 following cycles.
  task automatic expect_stream(input logic own, input int start, input int len);
    logic v;
    for (int k = 1; k <= len + 2; k++) begin
      tick();
      v = (k >= 2) && (k <= len + 1);
      chk($sformatf("rd%0d_valid k=%0d", own, k), own ? bus.rd1_valid : bus.rd0_valid, v);
      chk($sformatf("rd%0d_other_valid k=%0d", own, k), own ? bus.rd0_valid : bus.rd1_valid, 0);
      chk($sformatf("rd%0d_last k=%0d", own, k), own ? bus.rd1_last : bus.rd0_last, k == len + 1);
      if (v) chk($sformatf("rd%0d_data k=%0d", own, k), own ? bus.rd1_data : bus.rd0_data,
                 ((start + k - 2) % 512) & 255);
    end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    tb_rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_addr = '0;
    bus.req1_addr = '0;
    bus.req0_len = '0;
    bus.req1_len = '0;
    tick();
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_rd0_valid", bus.rd0_valid, 0);
    chk("rst_rd1_valid", bus.rd1_valid, 0);
    bus.req0_valid = 1'b0;
    tb_rst = 1'b0;
    tick();
    // Burst from requester 0
    bus.req0_addr = 9'd0;
    bus.req0_len = 10'd4;
    bus.req0_valid = 1'b1;
    #1;
    chk("b_ready0", bus.req0_ready, 1);
    chk("b_ready1", bus.req1_ready, 0);
    tick();
    chk("b_rom_addr", bus.rom_addr, 0);
    chk("b_busy", bus.busy, 1);
    chk("b_ready0_issue", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    expect_stream(1'b0, 0, 4);
    chk("b_busy_end", bus.busy, 0);
    // Wrapping burst from requester 1
    bus.req1_addr = 9'd510;
    bus.req1_len = 10'd4;
    bus.req1_valid = 1'b1;
    #1;
    chk("w_ready1", bus.req1_ready, 1);
    chk("w_ready0", bus.req0_ready, 0);
    tick();
    chk("w_rom_addr", bus.rom_addr, 510);
    bus.req1_valid = 1'b0;
    expect_stream(1'b1, 510, 4);
    // Contention with both requesters held valid
    bus.req0_addr = 9'h20;
    bus.req0_len = 10'd2;
    bus.req1_addr = 9'h40;
    bus.req1_len = 10'd2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    n_gr = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      bz[c] = bus.busy;
      if (bus.req0_ready || bus.req1_ready) begin
        gr[n_gr] = bus.req1_ready;
        tg[n_gr] = c;
        n_gr++;
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("c_grant_count", n_gr, 4);
    for (int g = 0; g < 4 && g < n_gr; g++) begin
`ifdef MELBANK_ARB_FIXED_PRIO_EN
      chk($sformatf("c_grant_owner%0d", g), gr[g], 0);
`else
      chk($sformatf("c_grant_owner%0d", g), gr[g], g % 2);
`endif
      chk($sformatf("c_grant_time%0d", g), tg[g], 4 * g);
    end
    for (int c = 0; c < 16; c++) chk($sformatf("c_busy%0d", c), bz[c], (c % 4) != 0);
    // Zero-length request
    bus.req0_addr = 9'd5;
    bus.req0_len = 10'd0;
    bus.req0_valid = 1'b1;
    #1;
    chk("z_ready0", bus.req0_ready, 1);
    tick();
    chk("z_busy", bus.busy, 0);
    chk("z_ready0_idle", bus.req0_ready, 1);
    bus.req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("z_rd0_valid%0d", k), bus.rd0_valid, 0);
      chk($sformatf("z_busy%0d", k), bus.busy, 0);
    end
    // Reset during the third ISSUE cycle of a len=8 burst
    bus.req0_addr = 9'h80;
    bus.req0_len = 10'd8;
    bus.req0_valid = 1'b1;
    #1;
    chk("r_ready0", bus.req0_ready, 1);
    tick();
    tick();
    tick();
    chk("r_pre_rd0_valid", bus.rd0_valid, 1);
    chk("r_pre_rd0_data", bus.rd0_data, 8'h80);
    chk("r_pre_rd1_data", bus.rd1_data, 8'h41);
    tb_rst = 1'b1;
    #1;
    chk("r_ready0", bus.req0_ready, 0);
    chk("r_ready1", bus.req1_ready, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_rom_addr", bus.rom_addr, 0);
    chk("r_rd0_valid", bus.rd0_valid, 0);
    chk("r_rd0_last", bus.rd0_last, 0);
    chk("r_rd0_data", bus.rd0_data, 0);
    chk("r_rd1_valid", bus.rd1_valid, 0);
    chk("r_rd1_data", bus.rd1_data, 0);
    bus.req0_valid = 1'b0;
    tick();
    tb_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("r_post_rd0_valid%0d", k), bus.rd0_valid, 0);
      chk($sformatf("r_post_rd0_last%0d", k), bus.rd0_last, 0);
      chk($sformatf("r_post_busy%0d", k), bus.busy, 0);
    end
    bus.req0_addr = 9'd16;
    bus.req0_len = 10'd1;
    bus.req0_valid = 1'b1;
    #1;
    chk("n_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    expect_stream(1'b0, 16, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/melbank_rom_arbiter.md
# melbank_rom_arbiter

Read arbiter and burst sequencer for the single-port MFCC mel-filterbank coefficient ROM (9-bit address, 8-bit data). It shares the ROM between two requesters: requester 0 is the filterbank MAC and requester 1 is the coefficient readback/debug path. Each requester submits a burst request (start address, word count). The block grants one burst at a time, streams ROM addresses one per cycle, and returns the data tagged to the owning requester with valid and last flags.

## Interface
- ADDR_WIDTH, 9: ROM address width.
- DATA_WIDTH, 8: ROM data width.
- LEN_WIDTH, 10: burst length field width; legal lengths are 0..2^ADDR_WIDTH.
- ROM_LATENCY, 1: ROM read latency in cycles. 1 when the ROM output register is off, 2 when it is on. Legal values are 1..2.

Ports:
- clk_tb  in  1  clock; all logic rising-edge.
- tb_rst  in  1  reset; asynchronous, active-high.
- req0_valid / req1_valid  in  1  burst request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_addr / req1_addr  in  ADDR_WIDTH  burst start address.
- req0_len / req1_len  in  LEN_WIDTH  number of words.
- rd0_valid / rd1_valid  out  1  return word valid.
- rd0_data / rd1_data  out  DATA_WIDTH  return word.
- rd0_last / rd1_last  out  1  final word of the burst.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_rddata  in  DATA_WIDTH  ROM read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- IDLE:
  - If any reqN_valid is high, the arbiter grants one requester and pulses reqN_ready for that single cycle.
  - Acceptance occurs when valid and ready are both high. On acceptance the block latches the address and length and records the owner.
  - If the accepted length is nonzero, the FSM goes to ISSUE.
  - If the accepted length is 0, the request is consumed, no data is returned, and the FSM stays in IDLE.
- ISSUE:
  - rom_addr is driven with start+i for i = 0..len-1, one address per cycle.
  - The address wraps modulo 2^ADDR_WIDTH.
  - After the last address is issued, the FSM goes to DRAIN.
  - reqN_ready stays low throughout ISSUE.
- DRAIN: the FSM holds for ROM_LATENCY cycles, then returns to IDLE. No request is accepted while in DRAIN.
- Arbitration is round-robin:
  - When both requests are valid, the requester not granted last wins.
  - The last-grant register resets to "1", so requester 0 wins the first tie.
  - A single valid requester always wins.
- Return path:
  - A shift register of depth ROM_LATENCY carries {issued, owner, last} alongside each address.
  - When an entry exits the shift register, rom_rddata is registered into rdN_data, and rdN_valid and rdN_last are registered for the owning requester.
  - The non-owning requester's valid and last outputs stay 0. Its data output holds its previous value.
- There is no backpressure on the return path. Requesters must sink one word per cycle.
- Reset, including reset asserted mid-burst:
  - All outputs go to 0: ready, valid, last, data, rom_addr and busy.
  - The FSM goes to IDLE and the in-flight shift register is cleared.
  - The current burst is discarded and no rdN_last is produced for it.

## Timing
- A request accepted at edge A drives rom_addr=start after A. The ROM samples that address at A+1.
- The first rdN_valid appears after edge A+1+ROM_LATENCY. Data then streams at one word per cycle for len cycles.
- rdN_last coincides with the len-th rdN_valid.
- The earliest next acceptance is in the first IDLE cycle after DRAIN, i.e. edge A+len+ROM_LATENCY+1.
- reqN_ready is combinational from IDLE state and the arbitration result. It is never high in ISSUE or DRAIN.
- Request inputs are sampled only on the acceptance edge. Changes to them during a burst have no effect.

## Configuration
- MELBANK_ARB_FIXED_PRIO_EN:
  - Defined: arbitration is fixed-priority. Requester 0 always wins when both requests are valid, and the last-grant register is not implemented.
  - Undefined: arbitration is round-robin as described in Operation.

## Test plan
ROM initialised with data = addr[7:0]; ROM_LATENCY=1.
- Burst: req0 addr=0, len=4 -> rd0_data 0x00,0x01,0x02,0x03 on consecutive cycles. First word after edge A+2. rd0_last on 0x03. rd1_valid stays 0.
- Wrap: req1 addr=510, len=4 -> rd1_data 0xFE,0xFF,0x00,0x01, last on 0x01.
- Contention: req0 and req1 held valid with len=2 each -> grants in order 0,1,0,1. Each acceptance is separated by 4 cycles. busy falls to 0 for one cycle between bursts.
- Zero length: req0 len=0 -> single-cycle req0_ready pulse; no rd0_valid; FSM stays in IDLE; busy stays 0.
- Reset mid-burst: tb_rst asserted during the third ISSUE cycle of a len=8 burst -> all outputs 0 immediately. After release, no rd0_valid or rd0_last appears for the aborted burst, and a new req0 addr=16, len=1 returns 0x10.
- With MELBANK_ARB_FIXED_PRIO_EN defined: both requesters continuously valid -> req0 is granted every time and req1 is never granted.
